// File: rtl/xm23_pkg.sv
// Shared types and constants for the XM23 run controller.
package xm23_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_PRIME     = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_IDLE = 3'd3,
    ST_STEP_HI   = 3'd4,
    ST_STEP_LO   = 3'd5,
    ST_HALT      = 3'd6
  } run_state_t;

  localparam logic [15:0] PROGRAM_FINISH = 16'h3FFF;
  localparam logic [14:0] PC_FORCE_ADDR  = 15'h7FFF;

  localparam int unsigned DEF_DIV_FAST  = 3;
  localparam int unsigned DEF_DIV_100HZ = 250_000;
  localparam int unsigned DEF_DIV_10HZ  = 2_500_000;
  localparam int unsigned DEF_DIV_1HZ   = 25_000_000;

  // Wide enough for the slowest half-period count.
  localparam int unsigned TIMER_W = 25;

endpackage

// File: rtl/half_period_timer.sv
// Free-running half-period counter; tc flags the last cycle of a div-cycle interval.
module half_period_timer
  import xm23_pkg::*;
(
  input  logic               clk_in,
  input  logic               init,
  input  logic               clr,
  input  logic [TIMER_W-1:0] div,
  output logic               tc
);

  logic [TIMER_W-1:0] timer;

  // >= rather than == so a shorter div after a speed change ends the count at once.
  assign tc = (timer >= (div - TIMER_W'(1)));

  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      timer <= '0;
    end else if (clr || tc) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/xm23_run_ctrl.sv
// XM23 run controller: core clock generation, PC priming, run/step sequencing,
// halt detection on the finish instruction and the core cycle counter.
module xm23_run_ctrl
  import xm23_pkg::*;
#(
  parameter int unsigned DIV_FAST     = DEF_DIV_FAST,
  parameter int unsigned DIV_100HZ    = DEF_DIV_100HZ,
  parameter int unsigned DIV_10HZ     = DEF_DIV_10HZ,
  parameter int unsigned DIV_1HZ      = DEF_DIV_1HZ,
  parameter int unsigned PRIME_CYCLES = 4,
  parameter int unsigned HALT_CONFIRM = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             init,
  input  logic [1:0]       speed,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic [15:0]      inst,
  output logic             cpu_clk,
  output logic             pc_force,
  output logic             led,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_o
);

  localparam int unsigned CONF_W = $clog2(HALT_CONFIRM + 1);

  run_state_t         state, state_d;
  logic               cpu_clk_d, led_d, pc_force_d, halted_d;
  logic [CNT_W-1:0]   count_d;
  logic [CONF_W-1:0]  confirm, confirm_d;
  logic               step_q, step_q2, step_edge;
  logic [TIMER_W-1:0] div, div_speed;
  logic               timer_clr, tc, rise, halt_pend;

  always_comb begin
    case (speed)
      2'b11:   div_speed = TIMER_W'(DIV_FAST);
      2'b10:   div_speed = TIMER_W'(DIV_100HZ);
      2'b01:   div_speed = TIMER_W'(DIV_10HZ);
      default: div_speed = TIMER_W'(DIV_1HZ);
    endcase
  end

  // The timer doubles as the PRIME-length counter.
  assign div       = (state == ST_PRIME) ? TIMER_W'(PRIME_CYCLES) : div_speed;
  assign timer_clr = (state inside {ST_RESET, ST_STEP_IDLE, ST_HALT});
  assign step_edge = step_q & ~step_q2;
  assign halt_pend = (confirm == CONF_W'(HALT_CONFIRM));
  assign state_o   = state;

  half_period_timer u_timer (
    .clk_in (clk_in),
    .init   (init),
    .clr    (timer_clr),
    .div    (div),
    .tc     (tc)
  );

  always_comb begin
    state_d   = state;
    cpu_clk_d = cpu_clk;
    led_d     = led;
    case (state)
      ST_RESET: state_d = ST_PRIME;
      ST_PRIME: begin
        if (tc) state_d = run_mode ? ST_RUN : ST_STEP_IDLE;
      end
      ST_RUN: begin
        if (tc) begin
          if (cpu_clk) begin
            cpu_clk_d = 1'b0;
            led_d     = ~led;
            // Mode switch only at the end of a high half; a pending halt finishes the low half first.
            if (!run_mode && !halt_pend) state_d = ST_STEP_IDLE;
          end else if (halt_pend) begin
            state_d = ST_HALT;
          end else begin
            cpu_clk_d = 1'b1;
            led_d     = ~led;
          end
        end
      end
      ST_STEP_IDLE: begin
        if (run_mode) begin
          state_d = ST_RUN;
        end else if (step_edge) begin
          state_d   = ST_STEP_HI;
          cpu_clk_d = 1'b1;
        end
      end
      ST_STEP_HI: begin
        if (tc) begin
          state_d   = ST_STEP_LO;
          cpu_clk_d = 1'b0;
        end
      end
      ST_STEP_LO: begin
        if (tc) state_d = halt_pend ? ST_HALT : ST_STEP_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
    pc_force_d = (state_d == ST_RESET) || (state_d == ST_PRIME);
    halted_d   = (state_d == ST_HALT);
  end

  // Halt confirmation and saturating cycle counter, both evaluated on core-clock rises.
  always_comb begin
    rise      = ~cpu_clk & cpu_clk_d;
    confirm_d = confirm;
    count_d   = cycle_count;
    if (rise) begin
      if (inst == PROGRAM_FINISH) begin
        if (!halt_pend) confirm_d = confirm + CONF_W'(1);
      end else begin
        confirm_d = '0;
      end
      if ((confirm_d != CONF_W'(HALT_CONFIRM)) && (cycle_count != '1)) begin
        count_d = cycle_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge init) begin
    if (init) begin
      state       <= ST_RESET;
      cpu_clk     <= 1'b0;
      led         <= 1'b0;
      pc_force    <= 1'b1;
      halted      <= 1'b0;
      cycle_count <= '0;
      confirm     <= '0;
      step_q      <= 1'b0;
      step_q2     <= 1'b0;
    end else begin
      state       <= state_d;
      cpu_clk     <= cpu_clk_d;
      led         <= led_d;
      pc_force    <= pc_force_d;
      halted      <= halted_d;
      cycle_count <= count_d;
      confirm     <= confirm_d;
      step_q      <= step_btn;
      step_q2     <= step_q;
    end
  end

endmodule

// File: tb/tb_xm23_run_ctrl.sv
// Self-checking bench for xm23_run_ctrl: directed run/step/halt/reset scenarios
// plus randomized single-step presses checked against a press-timeline model.
`timescale 1ns/1ps
module tb_xm23_run_ctrl;

  localparam int unsigned D_FAST = 3;
  localparam int unsigned D_100  = 250_000;
  localparam int unsigned D_10   = 5;
  localparam int unsigned D_1    = 4;
  localparam int unsigned PRIME  = 4;
  localparam int unsigned CONF   = 2;
  localparam int unsigned CW     = 32;

  logic          clk_in = 1'b0;
  logic          init, run_mode, step_btn;
  logic [1:0]    speed;
  logic [15:0]   inst;
  logic          cpu_clk, pc_force, led, halted;
  logic [CW-1:0] cycle_count;
  logic [2:0]    state_o;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int rel, x, first, per, a, h, r10, r12, r2, r3, last, dv, idx, ec, es;
  logic eclk;
  int acc[$];
  logic [1:0] sp_tab [3];
  int dv_tab [3];

  xm23_run_ctrl #(
    .DIV_FAST     (D_FAST),
    .DIV_100HZ    (D_100),
    .DIV_10HZ     (D_10),
    .DIV_1HZ      (D_1),
    .PRIME_CYCLES (PRIME),
    .HALT_CONFIRM (CONF),
    .CNT_W        (CW)
  ) dut (
    .clk_in      (clk_in),
    .init        (init),
    .speed       (speed),
    .run_mode    (run_mode),
    .step_btn    (step_btn),
    .inst        (inst),
    .cpu_clk     (cpu_clk),
    .pc_force    (pc_force),
    .led         (led),
    .halted      (halted),
    .cycle_count (cycle_count),
    .state_o     (state_o)
  );

  always #10 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk_in);
  endtask

  task automatic do_reset(input logic [1:0] spd, input logic rm, output int r);
    init = 1'b1; speed = spd; run_mode = rm; step_btn = 1'b0; inst = 16'h0000;
    repeat (3) @(negedge clk_in);
    init = 1'b0;
    r = cyc;
  endtask

  task automatic check_async_reset(input string tag);
    #2 init = 1'b1;
    #1;
    check({tag, "_cpu_clk"}, 32'(cpu_clk), 0);
    check({tag, "_count"}, cycle_count, 0);
    check({tag, "_pc_force"}, 32'(pc_force), 1);
    check({tag, "_state"}, 32'(state_o), 0);
  endtask

  // Free-running clock expectation: first rise at edge f, half-period d.
  function automatic int run_clk(input int k, input int f, input int d);
    if (k < f) return 0;
    return (((k - f) / d) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int run_rises(input int k, input int f, input int d);
    if (k < f) return 0;
    return (k - f) / (2 * d) + 1;
  endfunction

  initial begin
    sp_tab = '{2'b11, 2'b01, 2'b00};
    dv_tab = '{int'(D_FAST), int'(D_10), int'(D_1)};
    per = 2 * D_FAST;

    // Reset values, then prime and free run at the fast speed.
    init = 1'b1; speed = 2'b11; run_mode = 1'b1; step_btn = 1'b0; inst = 16'h0000;
    repeat (2) @(negedge clk_in);
    check("rst_cpu_clk", 32'(cpu_clk), 0);
    check("rst_pc_force", 32'(pc_force), 1);
    check("rst_led", 32'(led), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", cycle_count, 0);
    check("rst_state", 32'(state_o), 0);
    init = 1'b0;
    rel = cyc;
    x = rel + 1 + PRIME;
    first = x + D_FAST;
    for (int k = rel + 1; k <= rel + 40; k++) begin
      wait_cyc(k);
      check("prime_pc_force", 32'(pc_force), (k < x) ? 1 : 0);
      check("prime_state", 32'(state_o), (k < x) ? 1 : 2);
      check("run_cpu_clk", 32'(cpu_clk), run_clk(k, first, D_FAST));
      check("run_led", 32'(led), run_clk(k, first, D_FAST));
      check("run_count", cycle_count, run_rises(k, first, D_FAST));
    end

    // Speed change from the slow setting with the timer at 1000.
    do_reset(2'b10, 1'b1, rel);
    x = rel + 1 + PRIME;
    wait_cyc(x + 1000);
    check("slow_cpu_clk", 32'(cpu_clk), 0);
    check("slow_count", cycle_count, 0);
    speed = 2'b11;
    first = x + 1001;
    for (int k = x + 1001; k <= x + 1020; k++) begin
      wait_cyc(k);
      check("spd_cpu_clk", 32'(cpu_clk), run_clk(k, first, D_FAST));
      check("spd_count", cycle_count, run_rises(k, first, D_FAST));
    end

    // Single step: presses at a, a+2 (during STEP_HI, ignored), a+10, a+20.
    do_reset(2'b11, 1'b0, rel);
    x = rel + 1 + PRIME;
    wait_cyc(x + 2);
    check("step_idle_state", 32'(state_o), 3);
    a = cyc;
    for (int k = a; k <= a + 23; k++) begin
      wait_cyc(k);
      eclk = ((k >= a + 2 && k < a + 2 + D_FAST) || (k >= a + 12 && k < a + 12 + D_FAST) ||
              (k >= a + 22 && k < a + 22 + D_FAST));
      ec = ((k >= a + 2) ? 1 : 0) + ((k >= a + 12) ? 1 : 0) + ((k >= a + 22) ? 1 : 0);
      check("step_cpu_clk", 32'(cpu_clk), 32'(eclk));
      check("step_count", cycle_count, ec);
      check("step_led", 32'(led), 0);
      step_btn = (k == a || k == a + 2 || k == a + 10 || k == a + 20);
    end
    check("step_hi_state", 32'(state_o), 4);
    check_async_reset("areset_step_hi");

    // Halt after 10 normal rises followed by two finish-instruction rises.
    do_reset(2'b11, 1'b1, rel);
    x = rel + 1 + PRIME;
    first = x + D_FAST;
    r10 = first + 9 * per;
    r12 = first + 11 * per;
    h = r12 + per;
    for (int k = rel + 1; k <= h + 20; k++) begin
      wait_cyc(k);
      ec = run_rises(k, first, D_FAST);
      if (ec > 11) ec = 11;
      es = (k < h) ? run_clk(k, first, D_FAST) : 0;
      check("halt_cpu_clk", 32'(cpu_clk), es);
      check("halt_led", 32'(led), es);
      check("halt_count", cycle_count, ec);
      check("halt_flag", 32'(halted), (k >= h) ? 1 : 0);
      if (k == r10) inst = 16'h3FFF;
    end
    check("halt_state", 32'(state_o), 6);
    check_async_reset("areset_halt");

    // Single finish-instruction rise must not halt.
    do_reset(2'b11, 1'b1, rel);
    x = rel + 1 + PRIME;
    first = x + D_FAST;
    r2 = first + per;
    r3 = first + 2 * per;
    for (int k = rel + 1; k <= first + 8 * per; k++) begin
      wait_cyc(k);
      check("nohalt_cpu_clk", 32'(cpu_clk), run_clk(k, first, D_FAST));
      check("nohalt_count", cycle_count, run_rises(k, first, D_FAST));
      check("nohalt_flag", 32'(halted), 0);
      if (k == r2) inst = 16'h3FFF;
      if (k == r3) inst = 16'h0000;
    end

    // Randomized step presses at random speeds; a press is taken only once the
    // previous step (two half-periods) is fully over.
    for (int it = 0; it < 3; it++) begin
      idx = $urandom_range(0, 2);
      dv = dv_tab[idx];
      do_reset(sp_tab[idx], 1'b0, rel);
      x = rel + 1 + PRIME;
      acc.delete();
      last = -1000;
      for (int k = x; k < x + 200; k++) begin
        wait_cyc(k);
        eclk = 1'b0;
        ec = 0;
        foreach (acc[i]) begin
          if (k >= acc[i]) ec++;
          if (k >= acc[i] && k < acc[i] + dv) eclk = 1'b1;
        end
        check("rnd_cpu_clk", 32'(cpu_clk), 32'(eclk));
        check("rnd_count", cycle_count, ec);
        check("rnd_led", 32'(led), 0);
        check("rnd_halted", 32'(halted), 0);
        if (step_btn == 1'b0 && $urandom_range(0, 2) == 0) begin
          step_btn = 1'b1;
          if (k + 2 > last + 2 * dv) begin
            acc.push_back(k + 2);
            last = k + 2;
          end
        end else if (step_btn == 1'b1 && $urandom_range(0, 1) == 0) begin
          step_btn = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
